// File: rtl/nand_not_delay_model.sv
// -----------------------------------------------------------------------------
// nand_not_delay_model
//
// Cycle-based timing model of a 2-input NAND (NAND_2) and an inverter (NOT_1)
// with separate rise/fall delays and inertial (glitch-filtering) behaviour.
// Delays are counted in rising clock edges. Both gates share input a; the
// NAND also uses b. Each output is driven by its own delay channel and the two
// channels never interact.
//
// Ports:
//   clk     in   1  single clock, all sampling on the rising edge
//   rst     in   1  asynchronous, active-high reset (outputs return to 1)
//   a       in   1  gate input A (NAND and NOT)
//   b       in   1  gate input B (NAND only)
//   y_nand  out  1  registered, delayed ~(a & b)
//   y_not   out  1  registered, delayed ~a
//
// Parameters:
//   NAND_RISE / NAND_FALL  cycles for y_nand 0->1 / 1->0
//   NOT_RISE  / NOT_FALL   cycles for y_not  0->1 / 1->0
//   CNT_W                  delay counter width; every delay is 1..2^CNT_W-1
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// nand_not_delay_chan
//
// One inertial delay channel. The target t is sampled on every rising edge.
// A change of t away from y arms the channel (cnt = 1 on that first edge);
// y takes the new value on the edge where cnt reaches the delay D, i.e.
// exactly D edges after the first sampling edge. Any edge that sees t == y
// disarms the channel, so pulses shorter than D samples never reach y.
//
// Ports:
//   clk  in   1  clock
//   rst  in   1  asynchronous, active-high reset
//   t    in   1  combinational target value of the modelled gate
//   y    out  1  registered, delayed output
// -----------------------------------------------------------------------------
module nand_not_delay_chan #(
    parameter int unsigned RISE  = 1,
    parameter int unsigned FALL  = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic y
);

    localparam logic [CNT_W-1:0] RISE_C = RISE[CNT_W-1:0];
    localparam logic [CNT_W-1:0] FALL_C = FALL[CNT_W-1:0];
    localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Channel state: output value, armed flag, value being waited for and
    // number of consecutive edges the target has been held.
    logic             y_q,    y_n;
    logic             pend_q, pend_n;
    logic             tgt_q,  tgt_n;
    logic [CNT_W-1:0] cnt_q,  cnt_n;
    logic [CNT_W-1:0] dly;

    // State register. Reset discards any pending transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q    <= 1'b1;
            pend_q <= 1'b0;
            tgt_q  <= 1'b1;
            cnt_q  <= '0;
        end else begin
            y_q    <= y_n;
            pend_q <= pend_n;
            tgt_q  <= tgt_n;
            cnt_q  <= cnt_n;
        end
    end

    // Next-state logic. The branch order is the priority order: a target that
    // matches the output always cancels, even on the edge the delay expires.
    always_comb begin
        y_n    = y_q;
        pend_n = pend_q;
        tgt_n  = tgt_q;
        cnt_n  = cnt_q;
        dly    = t ? RISE_C : FALL_C;

        if (t == y_q) begin
            pend_n = 1'b0;
            cnt_n  = '0;
        end else if (!pend_q || (t != tgt_q)) begin
            // First edge sampling the new target counts as cycle 1.
            pend_n = 1'b1;
            tgt_n  = t;
            cnt_n  = ONE_C;
        end else if (cnt_q == dly) begin
            y_n    = tgt_q;
            pend_n = 1'b0;
            cnt_n  = '0;
        end else begin
            // cnt stops at dly, so this never wraps.
            cnt_n  = cnt_q + ONE_C;
        end
    end

    // Output logic: the output is the register itself, hence glitch-free.
    always_comb begin
        y = y_q;
    end

endmodule

module nand_not_delay_model #(
    parameter int unsigned NAND_RISE = 14,
    parameter int unsigned NAND_FALL = 10,
    parameter int unsigned NOT_RISE  = 7,
    parameter int unsigned NOT_FALL  = 5,
    parameter int unsigned CNT_W     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic y_nand,
    output logic y_not
);

    // Gate targets. A simultaneous change of a and b is one evaluation of
    // t_nand, so no intermediate value is ever seen by the channel.
    logic t_nand;
    logic t_not;

    always_comb begin
        t_nand = ~(a & b);
        t_not  = ~a;
    end

    nand_not_delay_chan #(
        .RISE  (NAND_RISE),
        .FALL  (NAND_FALL),
        .CNT_W (CNT_W)
    ) u_nand_chan (
        .clk (clk),
        .rst (rst),
        .t   (t_nand),
        .y   (y_nand)
    );

    nand_not_delay_chan #(
        .RISE  (NOT_RISE),
        .FALL  (NOT_FALL),
        .CNT_W (CNT_W)
    ) u_not_chan (
        .clk (clk),
        .rst (rst),
        .t   (t_not),
        .y   (y_not)
    );

endmodule

// File: tb/tb_nand_not_delay_model.sv
// -----------------------------------------------------------------------------
// tb_nand_not_delay_model
//
// Directed scenarios for reset, latency, glitch filtering and reset during a
// pending transition, followed by randomized input sequences. A reference
// model states the gate rule directly: an output flips to the new value once
// the target has been sampled different from the output on D+1 consecutive
// edges (the first sampling edge plus D more).
// -----------------------------------------------------------------------------
module tb_nand_not_delay_model;

    localparam int NAND_RISE = 14;
    localparam int NAND_FALL = 10;
    localparam int NOT_RISE  = 7;
    localparam int NOT_FALL  = 5;
    localparam int CNT_W     = 8;

    logic clk;
    logic rst;
    logic a;
    logic b;
    logic y_nand;
    logic y_not;

    int n_tests;
    int n_fail;

    // Reference model state.
    logic m_nand;
    logic m_not;
    int   run_nand;
    int   run_not;

    nand_not_delay_model #(
        .NAND_RISE (NAND_RISE),
        .NAND_FALL (NAND_FALL),
        .NOT_RISE  (NOT_RISE),
        .NOT_FALL  (NOT_FALL),
        .CNT_W     (CNT_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .y_nand (y_nand),
        .y_not  (y_not)
    );

    // ---------------------------------------------------------------- clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------------------------------------------------------- check
    task automatic check(input string tag, input logic obs, input logic exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    task automatic model_reset();
        m_nand   = 1'b1;
        m_not    = 1'b1;
        run_nand = 0;
        run_not  = 0;
    endtask

    // One channel: count consecutive samples that differ from the output;
    // the (D+1)-th such sample moves the output.
    task automatic model_chan(input logic t, input int rise, input int fall,
                              inout logic y, inout int run);
        int d;
        d = t ? rise : fall;
        if (t == y) begin
            run = 0;
        end else begin
            run++;
            if (run == d + 1) begin
                y   = t;
                run = 0;
            end
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else begin
            model_chan(~(a & b), NAND_RISE, NAND_FALL, m_nand, run_nand);
            model_chan(~a,       NOT_RISE,  NOT_FALL,  m_not,  run_not);
        end
    endtask

    // -------------------------------------------------------------- drivers
    // One rising edge: update the model with the inputs the DUT sampled, then
    // compare 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("y_nand_vs_model", y_nand, m_nand);
        check("y_not_vs_model",  y_not,  m_not);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_in(input logic va, input logic vb);
        a = va;
        b = vb;
    endtask

    // Asynchronous reset pulse placed between edges (called just after tick).
    task automatic async_reset_pulse();
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_async_y_nand", y_nand, 1'b1);
        check("rst_async_y_not",  y_not,  1'b1);
        #1;
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------- sequence
    initial begin
        logic nand_fell;
        logic not_fell;
        int   hold;

        n_tests = 0;
        n_fail  = 0;
        model_reset();
        rst = 1'b1;
        set_in(1'b0, 1'b0);

        // Reset with a=b=0.
        #1;
        check("reset_y_nand", y_nand, 1'b1);
        check("reset_y_not",  y_not,  1'b1);
        tick_n(3);
        #2 rst = 1'b0;

        // No change for 50 cycles after release.
        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle_y_nand", y_nand, 1'b1);
            check("idle_y_not",  y_not,  1'b1);
        end

        // b 0->1 with a=0: NAND target unchanged.
        set_in(1'b0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            tick();
            check("b_only_y_nand", y_nand, 1'b1);
            check("b_only_y_not",  y_not,  1'b1);
        end

        // a=b=1 at k0: y_not falls at k0+5, y_nand at k0+10.
        set_in(1'b1, 1'b1);
        tick_n(5);                      // edges k0..k0+4
        check("fall_not_before", y_not, 1'b1);
        tick();                         // edge k0+5
        check("fall_not_at_5", y_not, 1'b0);
        check("fall_nand_mid", y_nand, 1'b1);
        tick_n(4);                      // edge k0+9
        check("fall_nand_before", y_nand, 1'b1);
        tick();                         // edge k0+10
        check("fall_nand_at_10", y_nand, 1'b0);
        tick_n(10);

        // a->0 at k0: y_not rises at k0+7, y_nand at k0+14.
        set_in(1'b0, 1'b1);
        tick_n(7);                      // edges k0..k0+6
        check("rise_not_before", y_not, 1'b1 ^ 1'b1);
        tick();                         // edge k0+7
        check("rise_not_at_7", y_not, 1'b1);
        tick_n(6);                      // edge k0+13
        check("rise_nand_before", y_nand, 1'b0);
        tick();                         // edge k0+14
        check("rise_nand_at_14", y_nand, 1'b1);
        tick_n(20);

        // Glitch filter: a=b=1 for 9 edges must not move y_nand.
        nand_fell = 1'b0;
        set_in(1'b1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            tick();
            if (y_nand == 1'b0) nand_fell = 1'b1;
        end
        set_in(1'b0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (y_nand == 1'b0) nand_fell = 1'b1;
        end
        check("glitch9_nand_no_fall", nand_fell, 1'b0);

        // Glitch filter: a 4-edge pulse must not move y_not.
        not_fell = 1'b0;
        set_in(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (y_not == 1'b0) not_fell = 1'b1;
        end
        set_in(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (y_not == 1'b0) not_fell = 1'b1;
        end
        check("glitch4_not_no_fall", not_fell, 1'b0);

        // Reset 6 edges into a pending NAND fall, then a full 10-cycle fall.
        set_in(1'b1, 1'b1);
        tick_n(6);
        check("pre_rst_y_nand", y_nand, 1'b1);
        async_reset_pulse();
        tick_n(10);                     // edges k0..k0+9 after release
        check("post_rst_nand_before", y_nand, 1'b1);
        tick();                         // edge k0+10
        check("post_rst_nand_at_10", y_nand, 1'b0);
        tick_n(5);

        // Randomized segments, including occasional mid-run resets.
        for (int s = 0; s < 300; s++) begin
            set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            hold = (($urandom_range(0, 3) == 0) ? $urandom_range(1, 6)
                                                : $urandom_range(1, 20));
            tick_n(hold);
            if ($urandom_range(0, 39) == 0) async_reset_pulse();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
